modulo_barrido_display: RTL and testbench
=========================================

# modulo_barrido_display

Four-digit time-multiplexed scanner that sits directly upstream of `modulo_7segmentos`. It latches a 16-bit value and selects one nibble per refresh slot, driving that nibble onto the decoder's 4-bit `data` input. It generates the matching active-low anode enables, with dead-time between digits and optional leading-zero suppression. The decoder's 7-bit `display` output goes to the segment pins unchanged.

## Interface
- `REFRESH_DIV`, default 27000, clock cycles per digit slot (1 kHz per digit at 27 MHz); legal range ≥ 2.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `valor`  in  16  value to display; nibble 0 = [3:0] = rightmost digit.
- `carga`  in  1  load strobe; `valor` is captured on any edge where it is 1.
- `blank_ceros`  in  1  1 = suppress leading zeros.
- `data`  out  4  nibble for `modulo_7segmentos.data`.
- `anodos`  out  4  active-low digit enables; bit i = digit i.
- `digito`  out  2  index of the digit currently selected (debug/LED).

## Operation
- **Shadow register `sombra[15:0]`**
  - Loaded from `valor` on any edge where `carga`=1.
  - Holds otherwise.
  - Reset value 0.
- **Prescaler `cnt`**
  - Counts 0..REFRESH_DIV-1 and wraps.
  - `tick` = (`cnt` == REFRESH_DIV-1).
- **Digit index `idx[1:0]`**
  - Increments on `tick`, wrapping 3→0 (modulo 4).
  - No other state machine; the slot sequence 0,1,2,3,0,… is fixed.
- **Blank condition for digit i** (`blank_i`) is true when all of the following hold:
  - `blank_ceros`=1;
  - i≠0;
  - `sombra` nibbles i..3 are all zero.
  - Digit 0 always lights, so value 0 shows "0".
- **Dead-time:** when `cnt`==0 (first cycle of each slot), `anodos`=4'b1111. This prevents ghosting while `data` changes.
- **Registered outputs**, computed from the current `idx`, `cnt` and `sombra`:
  - `data` = `sombra[4*idx +: 4]`.
  - `digito` = `idx`.
  - `anodos` = 4'b1111 if `cnt`==0 or `blank_idx`; otherwise ~(4'b0001 << `idx`).
- **`data` while blanked:** `data` still carries the nibble, and the anode stays off.
- **Simultaneous `carga` and `tick`:** both take effect on the same edge. The new slot's output then uses the new `sombra`, one cycle later.
- **`carga` held high:** `sombra` tracks `valor` every cycle.
- **`rst` mid-scan:** takes effect on the next edge.
  - `cnt`, `idx`, `sombra` and all outputs return to reset values immediately.
  - No partial slot survives the reset.
- **Width rule:** `cnt` width = $clog2(REFRESH_DIV).

## Timing
- **Reset values:** `data`=4'h0, `anodos`=4'b1111, `digito`=2'd0.
- **Load latency:** `valor` captured at edge k (`carga`=1) → visible on `data` from edge k+1 while the matching digit is selected.
- **Slot length:** one slot is exactly REFRESH_DIV cycles.
  - `anodos` is off for 1 cycle, then one digit is low for REFRESH_DIV-1 cycles.
- **Full frame:** 4×REFRESH_DIV cycles.
- **After `rst` falls:**
  - The first edge outputs slot 0, dead cycle (`anodos` 1111).
  - The second edge drives `anodos`=4'b1110.
- **Output registration:** all outputs come from flops, with no combinational path from inputs to outputs.

## Structure
- **Package `display_pkg`**
  - `localparam N_DIGITS = 4`.
  - `localparam logic [3:0] ANODOS_OFF = 4'b1111`.
  - `typedef logic [3:0] nibble_t`.
  - `typedef logic [1:0] digit_idx_t`.
  - `modulo_7segmentos` may adopt `nibble_t` for its input without any functional change.
- **Sub-module `modulo_prescaler`**
  - Parameter `DIV`.
  - Ports `clk`, `rst`, `tick`, `cnt`.
  - Reusable for other refresh/debounce timing.
- **Top-level integration:** instantiate `modulo_barrido_display`, then `modulo_7segmentos`, with `data`→`data`.

## Test plan
REFRESH_DIV=4 throughout.
- **Reset:** hold `rst` for 3 cycles with `valor`=16'hFFFF and `carga`=1 → during reset `anodos`=1111, `data`=0, `digito`=0. After release, `data` becomes F from edge 2.
- **Scan order:** load 16'h1234 → the per-slot sequence is (`digito`,`data`,`anodos`) = (0,4,1110), (1,3,1101), (2,2,1011), (3,1,0111), repeating every 16 cycles. Each slot starts with 1 cycle of 1111.
- **Leading zeros:** load 16'h0040 with `blank_ceros`=1 → digits 2,3 keep `anodos`=1111 for the whole slot; digits 0,1 light with `data` 0,4. With `blank_ceros`=0, all four digits light.
- **Zero value:** load 16'h0000 with `blank_ceros`=1 → only digit 0 lights, `data`=0.
- **Load on slot boundary:** pulse `carga` with 16'hABCD on the same edge as the 3→0 `tick` → slot 0 shows `data`=D. No slot shows a mix of old and new nibbles.
- **Reset mid-scan:** assert `rst` for 1 cycle during slot 2 → the next edge shows `digito`=0, `anodos`=1111 and `sombra` cleared. Scanning then restarts at slot 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit multiplexed display path.
package display_pkg;
    localparam int         N_DIGITS   = 4;
    localparam logic [3:0] ANODOS_OFF = 4'b1111;

    typedef logic [3:0] nibble_t;
    typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/modulo_prescaler.sv
// Free-running modulo-DIV counter with a one-cycle tick on the last count.
module modulo_prescaler #(
    parameter  int DIV = 27000,
    localparam int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [CW-1:0] cnt
);
    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/modulo_barrido_display.sv
// Four-digit scanner: latches a 16-bit value and time-multiplexes its nibbles
// onto a 7-segment decoder with active-low anodes, dead-time and zero blanking.
module modulo_barrido_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] valor,
    input  logic        carga,
    input  logic        blank_ceros,
    output nibble_t     data,
    output logic [3:0]  anodos,
    output digit_idx_t  digito
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [15:0]   sombra;
    logic [CW-1:0] cnt;
    logic          tick;
    digit_idx_t    idx;
    logic          blank;
    logic [15:0]   alto;

    modulo_prescaler #(.DIV(REFRESH_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .cnt  (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sombra <= '0;
            idx    <= '0;
        end else begin
            if (carga) sombra <= valor;
            if (tick)  idx    <= idx + 2'd1;
        end
    end

    // Nibbles idx..3 all zero means this digit is a leading zero.
    always_comb begin
        alto  = sombra >> {idx, 2'b00};
        blank = blank_ceros && (idx != 2'd0) && (alto == 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data   <= '0;
            anodos <= ANODOS_OFF;
            digito <= '0;
        end else begin
            data   <= sombra[{idx, 2'b00} +: 4];
            digito <= idx;
            if (cnt == '0 || blank) anodos <= ANODOS_OFF;
            else                    anodos <= ~(4'b0001 << idx);
        end
    end
endmodule

// File: tb/tb_modulo_barrido_display.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-count based reference model of the scanner.
module tb_modulo_barrido_display;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] valor;
    logic        carga;
    logic        blank_ceros;
    logic [3:0]  data;
    logic [3:0]  anodos;
    logic [1:0]  digito;

    modulo_barrido_display #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .valor       (valor),
        .carga       (carga),
        .blank_ceros (blank_ceros),
        .data        (data),
        .anodos      (anodos),
        .digito      (digito)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_ok  = 0;

    // model state: cycles since reset and shadow value
    int          m_cyc = 0;
    logic [15:0] m_sh  = '0;
    int          e_data, e_an, e_dig;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step(input logic r, input logic c, input logic [15:0] v, input logic b);
        int slot, pos, digit;
        logic [15:0] upper;
        rst = r; carga = c; valor = v; blank_ceros = b;
        @(posedge clk);
        if (r) begin
            e_data = 0; e_an = 4'hF; e_dig = 0;
            m_cyc = 0; m_sh = '0;
        end else begin
            pos   = m_cyc % DIV;
            slot  = m_cyc / DIV;
            digit = slot % 4;
            upper = m_sh >> (4 * digit);
            e_data = int'(upper & 16'hF);
            e_dig  = digit;
            if (pos == 0 || (b && digit != 0 && upper == 0)) e_an = 4'hF;
            else e_an = 4'hF & ~(1 << digit);
            if (c) m_sh = v;
            m_cyc++;
        end
        #1;
        chk("data",   int'(data),   e_data);
        chk("anodos", int'(anodos), e_an);
        chk("digito", int'(digito), e_dig);
    endtask

    task automatic run(input int n, input logic b);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, $urandom, b);
    endtask

    initial begin
        // reset with load held high: shadow must stay cleared
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'hFFFF, 1'b0);
        chk("rst_anodos", int'(anodos), 4'hF);
        chk("rst_data",   int'(data),   0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("post_rst_data_F", int'(data), 4'hF);
        chk("post_rst_an",     int'(anodos), 4'b1110);

        // scan order
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        run(32, 1'b0);

        // leading zeros, then no blanking, then zero value
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        run(32, 1'b1);
        run(16, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        run(16, 1'b1);

        // load coinciding with the 3->0 tick
        while (m_cyc % (4 * DIV) != 4 * DIV - 1) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'hABCD, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("bound_data_D", int'(data), 4'hD);
        run(16, 1'b0);

        // reset in the middle of slot 2
        while (m_cyc % (4 * DIV) != 2 * DIV + 1) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("mid_rst_dig", int'(digito), 0);
        run(20, 1'b0);

        // random traffic
        for (int k = 0; k < 1500; k++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), logic'(k / 100 % 2));

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
